// File: rtl/tc_ps_gp_wr_arb.sv
// tc_ps_gp_wr_arb: round-robin arbiter/sequencer for the PL register-write bus.
// Owners may hold the bus for multi-beat sequences (req_last ends them). Optional
// idle gaps follow each write, and a stalled owner loses the bus after TMO idle cycles.
module tc_ps_gp_wr_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned AW   = 32,
  parameter int unsigned DW   = 32,
  parameter int unsigned GAP  = 0,
  parameter int unsigned TMO  = 255,
  localparam int unsigned IW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_last,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [AW-1:0]        addr,
  output logic [DW-1:0]        data,
  output logic                 wren,
  output logic [IW-1:0]        grant_id,
  output logic                 busy,
  output logic                 tmo
);

  localparam int unsigned CW       = IW + 1;
  localparam int unsigned IDLE_W   = 8;
  localparam int unsigned GAP_W    = 4;
  localparam int unsigned GAP_LAST = (GAP > 0) ? GAP - 1 : 0;
  localparam int unsigned TMO_LAST = (TMO > 0) ? TMO - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [IW-1:0]      ptr, ptr_next;
  logic [IW-1:0]      grant_next;
  logic [IDLE_W-1:0]  idle_cnt, idle_next;
  logic [GAP_W-1:0]   gap_cnt, gap_next;
  logic               seq_last, seq_last_next;
  logic               tmo_next;

  logic [AW-1:0]      addr_arr [NREQ];
  logic [DW-1:0]      data_arr [NREQ];
  logic               arb_hit;
  logic [IW-1:0]      arb_idx;
  logic [CW-1:0]      cand;
  logic [IW-1:0]      ptr_inc;
  logic               own_valid;
  logic               own_last;
  logic               accept;

  // Split the flattened request buses into per-requester words
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      addr_arr[i] = req_addr[i*AW +: AW];
      data_arr[i] = req_data[i*DW +: DW];
    end
  end

  // Round-robin pick: first valid requester at or above ptr, modulo NREQ
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = '0;
    cand    = '0;
    // Scan downward so the smallest offset from ptr is the final assignment
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + CW'(k);
      if (cand >= CW'(NREQ)) cand = cand - CW'(NREQ);
      if (req_valid[cand[IW-1:0]]) begin
        arb_hit = 1'b1;
        arb_idx = cand[IW-1:0];
      end
    end
  end

  assign own_valid = req_valid[grant_id];
  assign own_last  = req_last[grant_id];
  assign accept    = (state == S_OWN) && own_valid;
  assign ptr_inc   = (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + IW'(1);

  // State register plus arbitration/sequencing bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ptr      <= '0;
      grant_id <= '0;
      idle_cnt <= '0;
      gap_cnt  <= '0;
      seq_last <= 1'b0;
    end else begin
      state    <= state_next;
      ptr      <= ptr_next;
      grant_id <= grant_next;
      idle_cnt <= idle_next;
      gap_cnt  <= gap_next;
      seq_last <= seq_last_next;
    end
  end

  // Next-state: arbitration, beat acceptance, gap counting and stall timeout
  always_comb begin
    state_next    = state;
    ptr_next      = ptr;
    grant_next    = grant_id;
    idle_next     = idle_cnt;
    gap_next      = gap_cnt;
    seq_last_next = seq_last;
    tmo_next      = 1'b0;
    case (state)
      S_IDLE: begin
        if (arb_hit) begin
          grant_next = arb_idx;
          idle_next  = '0;
          state_next = S_OWN;
        end
      end
      S_OWN: begin
        if (own_valid) begin
          idle_next     = '0;
          seq_last_next = own_last;
          if (own_last) ptr_next = ptr_inc;
          if (GAP > 0) begin
            gap_next   = '0;
            state_next = S_GAP;
          end else if (own_last) begin
            state_next = S_IDLE;
          end
        end else if (idle_cnt == IDLE_W'(TMO_LAST)) begin
          // Owner stalled too long: reclaim the bus without issuing a write
          tmo_next   = 1'b1;
          idle_next  = '0;
          ptr_next   = ptr_inc;
          state_next = S_IDLE;
        end else begin
          idle_next = idle_cnt + IDLE_W'(1);
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_W'(GAP_LAST)) begin
          state_next = seq_last ? S_IDLE : S_OWN;
        end else begin
          gap_next = gap_cnt + GAP_W'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Handshake: only the current owner sees ready, and only while in OWN
  always_comb begin
    req_ready = '0;
    if (state == S_OWN) req_ready[grant_id] = 1'b1;
  end

  // Registered write port and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
      data <= '0;
      wren <= 1'b0;
      tmo  <= 1'b0;
      busy <= 1'b0;
    end else begin
      wren <= accept;
      tmo  <= tmo_next;
      busy <= (state_next != S_IDLE);
      if (accept) begin
        addr <= addr_arr[grant_id];
        data <= data_arr[grant_id];
      end
    end
  end

endmodule

// File: tb/tb_tc_ps_gp_wr_arb.sv
// Bench for tc_ps_gp_wr_arb: directed requester traffic with an expected-write
// scoreboard drained by a monitor that watches wren and tmo on two configurations.
module tb_tc_ps_gp_wr_arb;

  localparam int unsigned NREQ = 4;
  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned IW   = 2;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [IW-1:0] gid;
    logic          busy;
    int            cyc;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // DUT A: GAP=0, TMO=8.  DUT B: GAP=3, default TMO.
  logic               a_rst, b_rst;
  logic               a_v [NREQ], a_l [NREQ], b_v [NREQ], b_l [NREQ];
  logic [AW-1:0]      a_ad [NREQ], b_ad [NREQ];
  logic [DW-1:0]      a_dt [NREQ], b_dt [NREQ];
  logic [NREQ-1:0]    a_valid, a_last, b_valid, b_last;
  logic [NREQ*AW-1:0] a_addr_f, b_addr_f;
  logic [NREQ*DW-1:0] a_data_f, b_data_f;
  logic [NREQ-1:0]    a_rdy, b_rdy;
  logic [AW-1:0]      a_addr, b_addr;
  logic [DW-1:0]      a_data, b_data;
  logic               a_wren, b_wren, a_busy, b_busy, a_tmo, b_tmo;
  logic [IW-1:0]      a_gid, b_gid;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      a_valid[i] = a_v[i];
      a_last[i]  = a_l[i];
      a_addr_f[i*AW +: AW] = a_ad[i];
      a_data_f[i*DW +: DW] = a_dt[i];
      b_valid[i] = b_v[i];
      b_last[i]  = b_l[i];
      b_addr_f[i*AW +: AW] = b_ad[i];
      b_data_f[i*DW +: DW] = b_dt[i];
    end
  end

  tc_ps_gp_wr_arb #(.NREQ(NREQ), .AW(AW), .DW(DW), .GAP(0), .TMO(8)) u_a (
    .clk(clk), .rst(a_rst), .req_valid(a_valid), .req_last(a_last),
    .req_addr(a_addr_f), .req_data(a_data_f), .req_ready(a_rdy),
    .addr(a_addr), .data(a_data), .wren(a_wren), .grant_id(a_gid),
    .busy(a_busy), .tmo(a_tmo)
  );

  tc_ps_gp_wr_arb #(.NREQ(NREQ), .AW(AW), .DW(DW), .GAP(3)) u_b (
    .clk(clk), .rst(b_rst), .req_valid(b_valid), .req_last(b_last),
    .req_addr(b_addr_f), .req_data(b_data_f), .req_ready(b_rdy),
    .addr(b_addr), .data(b_data), .wren(b_wren), .grant_id(b_gid),
    .busy(b_busy), .tmo(b_tmo)
  );

  wr_t qa[$];
  wr_t qb[$];
  int  qta[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input bit b, input logic [AW-1:0] ad, input logic [DW-1:0] dt,
                      input logic [IW-1:0] gid, input logic bsy, input int c);
    wr_t e;
    e.addr = ad; e.data = dt; e.gid = gid; e.busy = bsy; e.cyc = c;
    if (b) qb.push_back(e);
    else   qa.push_back(e);
  endtask

  // Present one beat on requester i and hold it until accepted; check the accept cycle
  task automatic send(input bit b, input int i, input logic [AW-1:0] ad,
                      input logic [DW-1:0] dt, input logic lst, input int exp_acc);
    bit acc;
    int n;
    if (b) begin b_v[i] = 1'b1; b_l[i] = lst; b_ad[i] = ad; b_dt[i] = dt; end
    else   begin a_v[i] = 1'b1; a_l[i] = lst; a_ad[i] = ad; a_dt[i] = dt; end
    acc = 1'b0;
    n = 0;
    while (!acc && n < 40) begin
      @(negedge clk);
      acc = b ? (b_v[i] & b_rdy[i]) : (a_v[i] & a_rdy[i]);
      @(posedge clk);
      #1;
      n++;
    end
    if (b) b_v[i] = 1'b0;
    else   a_v[i] = 1'b0;
    chk($sformatf("%s_accept_cycle_r%0d", b ? "b" : "a", i), acc ? longint'(cyc - 1) : -1,
        longint'(exp_acc));
  endtask

  task automatic do_reset();
    a_rst = 1'b1;
    b_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    a_rst = 1'b0;
    b_rst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every wren/tmo the DUTs present is matched against the scoreboard
  always @(negedge clk) begin : mon
    wr_t e;
    if (a_wren) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_wren: got addr 0x%0h data 0x%0h, expected none (cycle %0d)",
                 a_addr, a_data, cyc);
      end else begin
        e = qa.pop_front();
        chk("a_wr_cycle", longint'(cyc), longint'(e.cyc));
        chk("a_wr_addr", longint'(a_addr), longint'(e.addr));
        chk("a_wr_data", longint'(a_data), longint'(e.data));
        chk("a_wr_gid", longint'(a_gid), longint'(e.gid));
        chk("a_wr_busy", longint'(a_busy), longint'(e.busy));
      end
    end
    if (a_tmo) begin
      if (qta.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_tmo: got tmo=1, expected 0 (cycle %0d)", cyc);
      end else begin
        chk("a_tmo_cycle", longint'(cyc), longint'(qta.pop_front()));
        chk("a_tmo_busy", longint'(a_busy), 0);
      end
    end
    if (b_wren) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_wren: got addr 0x%0h data 0x%0h, expected none (cycle %0d)",
                 b_addr, b_data, cyc);
      end else begin
        e = qb.pop_front();
        chk("b_wr_cycle", longint'(cyc), longint'(e.cyc));
        chk("b_wr_addr", longint'(b_addr), longint'(e.addr));
        chk("b_wr_data", longint'(b_data), longint'(e.data));
        chk("b_wr_gid", longint'(b_gid), longint'(e.gid));
        chk("b_wr_busy", longint'(b_busy), longint'(e.busy));
      end
    end
    if (b_tmo) begin
      checks++; errors++;
      $display("FAIL b_unexpected_tmo: got tmo=1, expected 0 (cycle %0d)", cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    a_rst = 1'b1;
    b_rst = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      a_v[i] = 1'b0; a_l[i] = 1'b0; a_ad[i] = '0; a_dt[i] = '0;
      b_v[i] = 1'b0; b_l[i] = 1'b0; b_ad[i] = '0; b_dt[i] = '0;
    end

    // 1: reset then idle, every output stays zero
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("idle_addr", longint'(a_addr), 0);
      chk("idle_data", longint'(a_data), 0);
      chk("idle_ctl", longint'({a_rdy, a_gid, a_wren, a_busy, a_tmo}), 0);
      chk("idle_ctl_b", longint'({b_rdy, b_gid, b_wren, b_busy, b_tmo}), 0);
    end
    @(posedge clk);
    #1;

    // 2: single beat from requester 1
    t = cyc;
    push(0, 32'h43C0_0010, 32'hA5A5_0001, 2'd1, 1'b0, t + 2);
    send(0, 1, 32'h43C0_0010, 32'hA5A5_0001, 1'b1, t + 1);
    idle(4);

    // 3: round robin 0,2,3 from a fresh reset
    do_reset();
    t = cyc;
    push(0, 32'h0000_1000, 32'h0000_0A00, 2'd0, 1'b0, t + 2);
    push(0, 32'h0000_1020, 32'h0000_0A20, 2'd2, 1'b0, t + 4);
    push(0, 32'h0000_1030, 32'h0000_0A30, 2'd3, 1'b0, t + 6);
    push(0, 32'h0000_1001, 32'h0000_0A01, 2'd0, 1'b0, t + 8);
    push(0, 32'h0000_1021, 32'h0000_0A21, 2'd2, 1'b0, t + 10);
    push(0, 32'h0000_1031, 32'h0000_0A31, 2'd3, 1'b0, t + 12);
    fork
      begin
        send(0, 0, 32'h0000_1000, 32'h0000_0A00, 1'b1, t + 1);
        send(0, 0, 32'h0000_1001, 32'h0000_0A01, 1'b1, t + 7);
      end
      begin
        send(0, 2, 32'h0000_1020, 32'h0000_0A20, 1'b1, t + 3);
        send(0, 2, 32'h0000_1021, 32'h0000_0A21, 1'b1, t + 9);
      end
      begin
        send(0, 3, 32'h0000_1030, 32'h0000_0A30, 1'b1, t + 5);
        send(0, 3, 32'h0000_1031, 32'h0000_0A31, 1'b1, t + 11);
      end
    join
    idle(4);

    // 4: requester 0 holds the bus for 4 beats while requester 1 waits
    t = cyc;
    push(0, 32'h43C0_0100, 32'hB000_0001, 2'd0, 1'b1, t + 2);
    push(0, 32'h43C0_0104, 32'hB000_0002, 2'd0, 1'b1, t + 3);
    push(0, 32'h43C0_0108, 32'hB000_0003, 2'd0, 1'b1, t + 4);
    push(0, 32'h43C0_010C, 32'hB000_0004, 2'd0, 1'b0, t + 5);
    push(0, 32'h43C0_0200, 32'hC000_0001, 2'd1, 1'b0, t + 7);
    fork
      begin
        send(0, 0, 32'h43C0_0100, 32'hB000_0001, 1'b0, t + 1);
        send(0, 0, 32'h43C0_0104, 32'hB000_0002, 1'b0, t + 2);
        send(0, 0, 32'h43C0_0108, 32'hB000_0003, 1'b0, t + 3);
        send(0, 0, 32'h43C0_010C, 32'hB000_0004, 1'b1, t + 4);
      end
      send(0, 1, 32'h43C0_0200, 32'hC000_0001, 1'b1, t + 6);
    join
    idle(4);

    // 6a: requester 1 stalls after its first beat; requester 3 takes over after tmo
    t = cyc;
    push(0, 32'h43C0_0300, 32'hD000_0001, 2'd1, 1'b1, t + 2);
    qta.push_back(t + 10);
    push(0, 32'h43C0_0400, 32'hE000_0001, 2'd3, 1'b0, t + 12);
    fork
      send(0, 1, 32'h43C0_0300, 32'hD000_0001, 1'b0, t + 1);
      begin
        idle(3);
        send(0, 3, 32'h43C0_0400, 32'hE000_0001, 1'b1, t + 11);
      end
    join
    idle(4);

    // 6b: reset asserted in the acceptance cycle suppresses the write
    t = cyc;
    a_v[0] = 1'b1; a_l[0] = 1'b1; a_ad[0] = 32'h43C0_0500; a_dt[0] = 32'hF000_0001;
    @(posedge clk);
    #1;
    a_rst = 1'b1;
    @(negedge clk);
    chk("rst_acc_ready", longint'(a_rdy[0]), 1);
    @(posedge clk);
    #1;
    a_rst = 1'b0;
    a_v[0] = 1'b0;
    @(negedge clk);
    chk("rst_acc_wren", longint'(a_wren), 0);
    chk("rst_acc_state", longint'({a_busy, a_gid, a_rdy}), 0);
    chk("rst_acc_addr", longint'(a_addr), 0);
    idle(4);

    // 5: GAP=3 instance, 3-beat burst from requester 2
    t = cyc;
    push(1, 32'h43C0_0600, 32'h1234_0001, 2'd2, 1'b1, t + 2);
    push(1, 32'h43C0_0604, 32'h1234_0002, 2'd2, 1'b1, t + 6);
    push(1, 32'h43C0_0608, 32'h1234_0003, 2'd2, 1'b1, t + 10);
    send(1, 2, 32'h43C0_0600, 32'h1234_0001, 1'b0, t + 1);
    send(1, 2, 32'h43C0_0604, 32'h1234_0002, 1'b0, t + 5);
    send(1, 2, 32'h43C0_0608, 32'h1234_0003, 1'b1, t + 9);
    while (cyc < t + 12) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("b_gap_busy_last_gap", longint'(b_busy), 1);
    chk("b_gap_ready_low", longint'(b_rdy), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("b_gap_busy_done", longint'(b_busy), 0);

    idle(6);
    chk("a_writes_outstanding", longint'(qa.size()), 0);
    chk("b_writes_outstanding", longint'(qb.size()), 0);
    chk("a_tmo_outstanding", longint'(qta.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
